tow_pull_encoder: RTL and testbench

Front end of the tug-of-war datapath: it turns each player's raw, bouncing, active-low push-button into a clean single-cycle pull pulse on the system clock. Its outputs, `pull_l` and `pull_r`, drive the `turnOn`/`turnOff` inputs of every playfield light cell. Each player input is synchronised, debounced and edge-detected, so one physical press yields exactly one pulse. Pulses are suppressed while the game is frozen (win displayed).

---
 rtl/tow_pkg.sv | 15 +
 rtl/key_conditioner.sv | 89 ++++++++
 rtl/tow_pull_encoder.sv | 52 +++++
 tb/tb_tow_pull_encoder.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/tow_pkg.sv
// Shared types and default constants for the tug-of-war input front end.
package tow_pkg;

  typedef enum logic [1:0] {
    KS_IDLE,
    KS_PRESS_CHK,
    KS_HELD,
    KS_REL_CHK
  } key_state_t;

  localparam int SYNC_DEFAULT   = 2;
  localparam int SIM_DEBOUNCE   = 4;
  localparam int BOARD_DEBOUNCE = 500000;

endpackage

// File: rtl/key_conditioner.sv
// One player button: synchroniser, press/release debounce FSM and
// single-cycle accept request on the PRESS_CHK to HELD transition.
module key_conditioner
  import tow_pkg::*;
#(
  parameter int SYNC_STAGES     = SYNC_DEFAULT,
  parameter int DEBOUNCE_CYCLES = SIM_DEBOUNCE
) (
  input  logic clk,
  input  logic reset,
  input  logic key_n,
  output logic accept
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES);

  logic [SYNC_STAGES-1:0] sync;
  logic                   p;
  key_state_t             state;
  key_state_t             state_nxt;
  logic [CW-1:0]          cnt;
  logic [CW-1:0]          cnt_nxt;

  // Released level is 1, so a reset synchroniser reads as not pressed.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync <= '1;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], key_n};
    end
  end

  assign p = ~sync[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= KS_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    accept    = 1'b0;
    unique case (state)
      KS_IDLE: begin
        if (p) begin
          state_nxt = KS_PRESS_CHK;
          cnt_nxt   = CNT_ONE;
        end
      end
      KS_PRESS_CHK: begin
        if (!p) begin
          state_nxt = KS_IDLE;
        end else if (cnt == CNT_MAX) begin
          state_nxt = KS_HELD;
          accept    = 1'b1;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      KS_HELD: begin
        if (!p) begin
          state_nxt = KS_REL_CHK;
          cnt_nxt   = CNT_ONE;
        end
      end
      KS_REL_CHK: begin
        if (p) begin
          state_nxt = KS_HELD;
        end else if (cnt == CNT_MAX) begin
          state_nxt = KS_IDLE;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      default: begin
        state_nxt = KS_IDLE;
      end
    endcase
  end

endmodule

// File: rtl/tow_pull_encoder.sv
// Two independent button conditioners with freeze gating and
// registered single-cycle pull pulses for the light cells.
module tow_pull_encoder
  import tow_pkg::*;
#(
  parameter int SYNC_STAGES     = SYNC_DEFAULT,
  parameter int DEBOUNCE_CYCLES = SIM_DEBOUNCE
) (
  input  logic clk,
  input  logic reset,
  input  logic key_l_n,
  input  logic key_r_n,
  input  logic freeze,
  output logic pull_l,
  output logic pull_r
);

  logic accept_l;
  logic accept_r;

  key_conditioner #(
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_left (
    .clk   (clk),
    .reset (reset),
    .key_n (key_l_n),
    .accept(accept_l)
  );

  key_conditioner #(
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_right (
    .clk   (clk),
    .reset (reset),
    .key_n (key_r_n),
    .accept(accept_r)
  );

  // A press accepted while frozen is dropped, never deferred.
  always_ff @(posedge clk) begin
    if (reset) begin
      pull_l <= 1'b0;
      pull_r <= 1'b0;
    end else begin
      pull_l <= accept_l & ~freeze;
      pull_r <= accept_r & ~freeze;
    end
  end

endmodule

// File: tb/tb_tow_pull_encoder.sv
// Bench for tow_pull_encoder: vector table, timed corner sequences and
// random stimulus against a run-length reference model.
module tb_tow_pull_encoder;

  logic clk;
  logic rst;
  logic frz;
  logic ka_l, ka_r, kb_l, kb_r;
  logic pa_l, pa_r, pb_l, pb_r;

  int n_chk;
  int n_fail;
  int n_rand_pulses;

  tow_pull_encoder u_a (
    .clk    (clk),
    .reset  (rst),
    .key_l_n(ka_l),
    .key_r_n(ka_r),
    .freeze (frz),
    .pull_l (pa_l),
    .pull_r (pa_r)
  );

  tow_pull_encoder #(
    .SYNC_STAGES    (3),
    .DEBOUNCE_CYCLES(1)
  ) u_b (
    .clk    (clk),
    .reset  (rst),
    .key_l_n(kb_l),
    .key_r_n(kb_r),
    .freeze (frz),
    .pull_l (pb_l),
    .pull_r (pb_r)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: a level change is accepted after d+1 consecutive
  // synchronised samples that differ from the accepted level.
  typedef struct {
    logic [3:0] dl;
    int         run;
    bit         held;
    bit         exp;
  } mdl_t;

  mdl_t ma_l, ma_r, mb_l, mb_r;

  function automatic void mstep(inout mdl_t m, input int n, input int d,
                                input logic key, input logic fz,
                                input logic rs);
    bit p;
    bit acc;
    if (rs) begin
      m.dl   = 4'hF;
      m.run  = 0;
      m.held = 1'b0;
      m.exp  = 1'b0;
    end else begin
      p   = ~m.dl[n-1];
      acc = 1'b0;
      if (p != m.held) m.run++;
      else m.run = 0;
      if (m.run == d + 1) begin
        m.held = p;
        m.run  = 0;
        acc    = p;
      end
      m.exp = acc & ~fz;
      m.dl  = {m.dl[2:0], key};
    end
  endfunction

  initial begin
    ma_l = '{4'hF, 0, 1'b0, 1'b0};
    ma_r = '{4'hF, 0, 1'b0, 1'b0};
    mb_l = '{4'hF, 0, 1'b0, 1'b0};
    mb_r = '{4'hF, 0, 1'b0, 1'b0};
  end

  always @(posedge clk) begin
    mstep(ma_l, 2, 4, ka_l, frz, rst);
    mstep(ma_r, 2, 4, ka_r, frz, rst);
    mstep(mb_l, 3, 1, kb_l, frz, rst);
    mstep(mb_r, 3, 1, kb_r, frz, rst);
  end

  task automatic chk(input string nm, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic run_expect(input string nm, input int inst,
                            input int cycles, input int at_l,
                            input int at_r);
    for (int i = 0; i < cycles; i++) begin
      tick();
      if (inst == 0) begin
        chk($sformatf("%s_l[%0d]", nm, i), pa_l, i == at_l);
        chk($sformatf("%s_r[%0d]", nm, i), pa_r, i == at_r);
      end else begin
        chk($sformatf("%s_l[%0d]", nm, i), pb_l, i == at_l);
        chk($sformatf("%s_r[%0d]", nm, i), pb_r, i == at_r);
      end
    end
  endtask

  typedef struct {
    bit kl;
    bit kr;
    bit rs;
    bit el;
    bit er;
  } vec_t;

  vec_t tbl[$];

  initial begin
    n_chk = 0;
    n_fail = 0;
    n_rand_pulses = 0;
    rst = 1'b1;
    frz = 1'b0;
    ka_l = 1'b1; ka_r = 1'b1; kb_l = 1'b1; kb_r = 1'b1;

    tbl.push_back('{1'b1, 1'b1, 1'b1, 1'b0, 1'b0});
    tbl.push_back('{1'b1, 1'b1, 1'b0, 1'b0, 1'b0});
    for (int i = 0; i < 20; i++)
      tbl.push_back('{1'b0, 1'b1, 1'b0, i == 6, 1'b0});
    for (int i = 0; i < 10; i++)
      tbl.push_back('{1'b1, 1'b1, 1'b0, 1'b0, 1'b0});
    for (int i = 0; i < 12; i++)
      tbl.push_back('{1'b0, 1'b0, 1'b0, i == 6, i == 6});
    for (int i = 0; i < 10; i++)
      tbl.push_back('{1'b1, 1'b1, 1'b0, 1'b0, 1'b0});

    tick();
    tick();
    chk("reset_a_l", pa_l, 1'b0);
    chk("reset_a_r", pa_r, 1'b0);
    chk("reset_b_l", pb_l, 1'b0);
    chk("reset_b_r", pb_r, 1'b0);

    for (int i = 0; i < tbl.size(); i++) begin
      ka_l = tbl[i].kl;
      ka_r = tbl[i].kr;
      rst  = tbl[i].rs;
      tick();
      chk($sformatf("vec_l[%0d]", i), pa_l, tbl[i].el);
      chk($sformatf("vec_r[%0d]", i), pa_r, tbl[i].er);
    end

    // press bounce 0,1,0,1 then settled low
    ka_r = 1'b0; tick(); chk("bounce0", pa_r, 1'b0);
    ka_r = 1'b1; tick(); chk("bounce1", pa_r, 1'b0);
    ka_r = 1'b0; tick(); chk("bounce2", pa_r, 1'b0);
    ka_r = 1'b1; tick(); chk("bounce3", pa_r, 1'b0);
    ka_r = 1'b0;
    run_expect("bounce_press", 0, 14, -1, 6);
    ka_r = 1'b1; tick(); chk("relb0", pa_r, 1'b0);
    ka_r = 1'b0; tick(); chk("relb1", pa_r, 1'b0);
    ka_r = 1'b1;
    run_expect("bounce_rel", 0, 20, -1, -1);

    // freeze exactly on the acceptance edge
    ka_l = 1'b0;
    run_expect("frz_pre", 0, 6, -1, -1);
    frz = 1'b1;
    tick();
    chk("frz_edge", pa_l, 1'b0);
    frz = 1'b0;
    run_expect("frz_held", 0, 12, -1, -1);
    ka_l = 1'b1;
    run_expect("frz_rel", 0, 12, -1, -1);
    ka_l = 1'b0;
    run_expect("frz_again", 0, 12, 6, -1);
    ka_l = 1'b1;
    run_expect("frz_rel2", 0, 12, -1, -1);

    // reset mid-PRESS_CHK, key held through reset
    ka_l = 1'b0;
    run_expect("rst_pre", 0, 5, -1, -1);
    rst = 1'b1;
    run_expect("rst_on", 0, 2, -1, -1);
    rst = 1'b0;
    run_expect("rst_post", 0, 14, 6, -1);
    ka_l = 1'b1;
    run_expect("rst_rel", 0, 12, -1, -1);

    // reset on the edge that would register the pulse
    ka_r = 1'b0;
    run_expect("rstp_pre", 0, 6, -1, -1);
    rst = 1'b1;
    tick();
    chk("rstp_l", pa_l, 1'b0);
    chk("rstp_r", pa_r, 1'b0);
    rst = 1'b0;
    run_expect("rstp_post", 0, 12, -1, 6);
    ka_r = 1'b1;
    run_expect("rstp_rel", 0, 12, -1, -1);

    // SYNC_STAGES=3, DEBOUNCE_CYCLES=1: pulse after edge 4, no repeat
    kb_l = 1'b0;
    run_expect("sweep_hold", 1, 200, 4, -1);
    kb_l = 1'b1;
    run_expect("sweep_rel", 1, 8, -1, -1);
    kb_r = 1'b0;
    run_expect("sweep_r", 1, 10, -1, 4);
    kb_r = 1'b1;
    run_expect("sweep_rrel", 1, 8, -1, -1);

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 5) == 0) ka_l = ~ka_l;
      if ($urandom_range(0, 5) == 0) ka_r = ~ka_r;
      if ($urandom_range(0, 3) == 0) kb_l = ~kb_l;
      if ($urandom_range(0, 3) == 0) kb_r = ~kb_r;
      if ($urandom_range(0, 19) == 0) frz = ~frz;
      rst = ($urandom_range(0, 299) == 0);
      tick();
      chk($sformatf("rnd_a_l[%0d]", i), pa_l, ma_l.exp);
      chk($sformatf("rnd_a_r[%0d]", i), pa_r, ma_r.exp);
      chk($sformatf("rnd_b_l[%0d]", i), pb_l, mb_l.exp);
      chk($sformatf("rnd_b_r[%0d]", i), pb_r, mb_r.exp);
      n_rand_pulses += int'(ma_l.exp) + int'(ma_r.exp)
                     + int'(mb_l.exp) + int'(mb_r.exp);
    end
    chk("rnd_pulses_seen", n_rand_pulses > 10, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
